// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding and a
// width helper used to size the owner index and the beat counter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Smallest r such that 2**r >= v (v >= 1); constant-foldable for widths.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester with req high, searching
// upward modulo NREQ starting just after last_owner.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_owner,
    output logic [NREQ-1:0] onehot,
    output logic            valid
);

    // Walk the NREQ candidate positions in priority order and take the first hit.
    always_comb begin
        int idx;
        onehot = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_owner) + k) % NREQ;
            if (!valid && req[idx]) begin
                onehot[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// A grant lasts until the owner drops req or completes MAXBURST beats; the next
// owner is loaded on the releasing edge so back-to-back grants have no bubble.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic                  wfull,
    output logic [NREQ-1:0]       gnt,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  busy
);

    localparam int IW = clog2(NREQ);
    localparam int BW = clog2(MAXBURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAXBURST - 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_owner_q, last_owner_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [IW-1:0]   pick_last;
    logic [NREQ-1:0] pick_onehot;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            beat;
    logic            release_now;

    assign busy  = (state_q == GRANT);
    assign gnt   = gnt_q;
    assign beat  = busy & req[owner_q] & ~wfull;
    assign winc  = beat;
    assign wdata = req_data[int'(owner_q)*DSIZE +: DSIZE];

    // Release when the owner goes quiet or its final permitted beat is taken.
    assign release_now = busy & (~req[owner_q] | (beat & (beat_cnt_q == LAST_BEAT)));

    // While granted, the search restarts after the current (releasing) owner.
    assign pick_last = busy ? owner_q : last_owner_q;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req        (req),
        .last_owner (pick_last),
        .onehot     (pick_onehot),
        .valid      (pick_valid)
    );

    // Convert the picker's one-hot result into an owner index.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) begin
                pick_idx = IW'(i);
            end
        end
    end

    // Next-state logic: grant on demand, count beats, rotate on release.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = GRANT;
                    gnt_d      = pick_onehot;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_owner_d = owner_q;
                    beat_cnt_d   = '0;
                    if (pick_valid) begin
                        gnt_d   = pick_onehot;
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // State register; reset points the first search at requester 0.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= IW'(NREQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;

    localparam int NREQ     = 4;
    localparam int DSIZE    = 8;
    localparam int MAXBURST = 4;

    logic        wclk = 1'b0;
    logic        wrst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        wfull;
    logic [3:0]  gnt;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .NREQ     (NREQ),
        .DSIZE    (DSIZE),
        .MAXBURST (MAXBURST)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .req      (req),
        .req_data (req_data),
        .wfull    (wfull),
        .gnt      (gnt),
        .winc     (winc),
        .wdata    (wdata),
        .busy     (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_own;    // current owner, -1 when nobody holds the port
    int         m_last;   // requester released most recently
    int         m_beats;  // beats taken under the current grant
    logic [7:0] cnt [4];  // per-requester data sequence counters

    task automatic model_reset();
        m_own   = -1;
        m_last  = NREQ - 1;
        m_beats = 0;
    endtask

    function automatic int pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [7:0] word_of(input int i);
        return 8'(i * 64) | (cnt[i] & 8'h3f);
    endfunction

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = word_of(i);
    endtask

    // One model-checked clock cycle with the inputs already applied.
    task automatic step();
        logic [3:0] eg;
        logic       ew;
        int         beat_i;
        @(negedge wclk);
        if (wrst) model_reset();
        eg = (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
        ew = (m_own >= 0) && req[m_own] && !wfull;
        chk("gnt", gnt, eg);
        chk("busy", busy, m_own >= 0);
        chk("winc", winc, ew);
        chk("gnt_onehot0", $onehot0(gnt), 1);
        if (ew) chk("wdata", wdata, word_of(m_own));
        beat_i = ew ? m_own : -1;
        if (wrst) begin
            model_reset();
        end else if (m_own < 0) begin
            m_own   = pick(m_last, req);
            m_beats = 0;
        end else if (!req[m_own] || (ew && m_beats == MAXBURST - 1)) begin
            m_last  = m_own;
            m_own   = pick(m_last, req);
            m_beats = 0;
        end else if (ew) begin
            m_beats++;
        end
        @(posedge wclk);
        #1;
        if (beat_i >= 0) cnt[beat_i] = cnt[beat_i] + 8'd1;
        drive_data();
    endtask

    // One cycle with hand-derived expectations (data counters frozen).
    task automatic expect_cycle(input string name, input logic [3:0] eg, input logic ew, input logic [7:0] ed);
        @(negedge wclk);
        chk({name, "_gnt"}, gnt, eg);
        chk({name, "_winc"}, winc, ew);
        if (ew) chk({name, "_wdata"}, wdata, ed);
        $display("%s: req=%b wfull=%b gnt=%b winc=%b wdata=%h", name, req, wfull, gnt, winc, wdata);
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst  = 1'b1;
        req   = 4'b0000;
        wfull = 1'b0;
        for (int i = 0; i < NREQ; i++) cnt[i] = 8'd0;
        drive_data();
        model_reset();
        @(posedge wclk);
        #1;
        wrst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       wfull;
        logic [3:0] gnt;
        logic       winc;
        logic       busy;
        logic [7:0] wdata;
    } vec_t;

    vec_t vt [19];

    initial begin
        // Requester i presents the constant word 8'h11*(i+1) during the table.
        vt[0]  = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00};
        vt[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h11};
        vt[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h11};
        vt[4]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h11};
        vt[5]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h11};
        vt[6]  = '{1'b0, 4'b0101, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h11};
        vt[7]  = '{1'b0, 4'b0101, 1'b0, 4'b0001, 1'b1, 1'b1, 8'h11};
        vt[8]  = '{1'b0, 4'b0100, 1'b0, 4'b0001, 1'b0, 1'b1, 8'h00};
        vt[9]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h33};
        vt[10] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1, 8'h00};
        vt[11] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b1, 8'h00};
        vt[12] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h33};
        vt[13] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h33};
        vt[14] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h33};
        vt[15] = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1, 8'h00};
        vt[16] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00};
        vt[17] = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00};
        vt[18] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1, 8'h44};

        req_data = 32'h44332211;
        for (int r = 0; r < 19; r++) begin
            wrst  = vt[r].rst;
            req   = vt[r].req;
            wfull = vt[r].wfull;
            @(negedge wclk);
            chk($sformatf("vec%0d_gnt", r), gnt, vt[r].gnt);
            chk($sformatf("vec%0d_winc", r), winc, vt[r].winc);
            chk($sformatf("vec%0d_busy", r), busy, vt[r].busy);
            if (vt[r].winc) chk($sformatf("vec%0d_wdata", r), wdata, vt[r].wdata);
            $display("vec%0d: rst=%b req=%b wfull=%b gnt=%b winc=%b busy=%b wdata=%h",
                     r, wrst, req, wfull, gnt, winc, busy, wdata);
            @(posedge wclk);
            #1;
        end

        // Full contention: strict rotation 0,1,2,3,0 with four beats each.
        do_reset();
        req = 4'b1111;
        expect_cycle("rot_idle", 4'b0000, 1'b0, 8'h00);
        for (int c = 1; c <= 17; c++) begin
            expect_cycle($sformatf("rot%0d", c), 4'(1 << (((c - 1) / 4) % 4)), 1'b1,
                         8'(((((c - 1) / 4) % 4)) * 64));
        end

        // Long wfull stall after one beat: grant held, three beats afterwards, then rotate.
        do_reset();
        req = 4'b0110;
        expect_cycle("stall_idle", 4'b0000, 1'b0, 8'h00);
        expect_cycle("stall_beat1", 4'b0010, 1'b1, 8'h40);
        wfull = 1'b1;
        for (int c = 0; c < 10; c++) expect_cycle($sformatf("stall_full%0d", c), 4'b0010, 1'b0, 8'h00);
        wfull = 1'b0;
        for (int c = 2; c <= 4; c++) expect_cycle($sformatf("stall_beat%0d", c), 4'b0010, 1'b1, 8'h40);
        expect_cycle("stall_rotate", 4'b0100, 1'b1, 8'h80);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        req = 4'b0001;
        step();
        step();
        step();
        #2;
        wrst = 1'b1;
        #1;
        chk("async_rst_gnt", gnt, 4'b0000);
        chk("async_rst_winc", winc, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        $display("async_rst: gnt=%b winc=%b busy=%b", gnt, winc, busy);
        model_reset();
        req = 4'b1010;
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        step();
        @(negedge wclk);
        chk("post_rst_gnt", gnt, 4'b0010);
        $display("post_rst: gnt=%b", gnt);
        @(posedge wclk);
        #1;
        do_reset();

        // Randomized traffic with occasional resets and FIFO-full back-pressure.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) req[i] = ($urandom_range(0, 9) < 3);
                else         req[i] = ($urandom_range(0, 9) != 0);
            end
            wfull = ($urandom_range(0, 3) == 0);
            wrst  = ($urandom_range(0, 299) == 0);
            step();
        end
        wrst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters sharing one async-FIFO write port (2..8).
REQ-002 Parameter DSIZE, default 8: data width per requester and to the FIFO.
REQ-003 Parameter MAXBURST, default 4: maximum beats per grant before forced rotation (1..15).
REQ-004 wclk  input  1  write-domain clock; the block's only clock.
REQ-005 wrst  input  1  reset, asynchronous assert, active-high.
REQ-006 req  input  NREQ  per-requester write request; held high while data is valid.
REQ-007 req_data  input  NREQ*DSIZE  flattened per-requester data; requester i occupies bits [i*DSIZE +: DSIZE].
REQ-008 wfull  input  1  full flag from the FIFO write-pointer logic.
REQ-009 gnt  output  NREQ  one-hot (or zero) registered grant.
REQ-010 winc  output  1  FIFO write enable.
REQ-011 wdata  output  DSIZE  FIFO write data.
REQ-012 busy  output  1  high in state GRANT.

Function
REQ-013 State machine states: IDLE (gnt=0) and GRANT (exactly one gnt bit set).
REQ-014 IDLE->GRANT when any req bit is high; the new owner is the first requester with req high, searching upward modulo NREQ from last_owner+1.
REQ-015 The grant is registered: gnt rises one cycle after req is sampled in IDLE.
REQ-016 Beat condition: winc = busy & req[owner] & ~wfull, combinational; wdata = req_data slice of owner, combinational.
REQ-017 beat_cnt (width ceil(log2(MAXBURST+1))) clears on each new grant and increments on each beat; wfull-stalled cycles do not count.
REQ-018 Release on the first cycle where req[owner]=0, or when a beat occurs with beat_cnt = MAXBURST-1.
REQ-019 On release, if any req is pending (the releasing requester is included), the next owner is selected per REQ-014 with last_owner = releasing owner and loaded on the same clock edge (GRANT->GRANT, no idle bubble); otherwise GRANT->IDLE.
REQ-020 last_owner updates on every release.
REQ-021 wfull held high: owner keeps its grant indefinitely with winc=0; there is no timeout.
REQ-022 wfull deasserting with the owner's req still high: a beat occurs in that same cycle.
REQ-023 A requester must not deassert req after a beat without further data; the arbiter never issues winc for a requester whose req is low.
REQ-024 Single requester with continuous req: after MAXBURST beats it is released and regranted on the same edge, producing one rotation point with no lost cycle.

Reset
REQ-025 wrst high, asynchronous: state=IDLE, gnt=0, beat_cnt=0, last_owner=NREQ-1 (first search starts at requester 0).
REQ-026 During reset winc=0 and busy=0.
REQ-027 Reset asserted mid-burst: the in-flight beat in that cycle is not guaranteed; no winc after assertion.
REQ-028 Operation resumes on the first wclk edge after wrst falls.

Structure
REQ-029 Shared package fifo_arb_pkg holds the state encoding (IDLE=0, GRANT=1) and the log2 helper function.
REQ-030 Sub-module rr_pick: combinational round-robin picker, inputs req[NREQ] and last_owner, outputs onehot[NREQ] and valid; one instance.
REQ-031 All state in a single wclk process; no logic in other clock domains.

Verification
REQ-032 NREQ=4; req=0001 held, wfull=0 -> gnt=0001 at cycle 1; four winc beats; regrant at the same edge; winc continuous.
REQ-033 req=1111 held -> grants rotate 0001,0010,0100,1000,0001, each with 4 beats; wdata matches the owner slice on every beat.
REQ-034 Owner 0 drops req after 2 beats while req[2] is high -> next edge gnt=0100, beat_cnt=0, no bubble cycle.
REQ-035 wfull=1 for 10 cycles mid-burst (1 beat done) -> gnt stable, winc=0, beat_cnt=1; after wfull falls, 3 more beats then release.
REQ-036 wrst pulsed during a burst -> gnt=0, winc=0 immediately; first grant after reset goes to the lowest pending requester.
REQ-037 Scoreboard: FIFO write sequence equals per-requester data in grant order; gnt is always one-hot or zero (assertion).
